// File: rtl/mesh_hs_monitor.sv
// Passive monitor for the pndng/pop handshake on every mesh terminal, both directions:
// per-channel timeout FSMs, spurious-pop and data-stability checks, sticky flags, transfer counters.
module mesh_hs_monitor #(
  parameter int NTERM   = 16,
  parameter int PCKG_SZ = 40,
  parameter int TIMEOUT = 50,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NTERM-1:0]           pndng,
  input  logic [NTERM-1:0]           pop,
  input  logic [NTERM*PCKG_SZ-1:0]   data_out,
  input  logic [NTERM-1:0]           pndng_i_in,
  input  logic [NTERM-1:0]           popin,
  input  logic                       clr_err,
  input  logic [$clog2(NTERM)-1:0]   cnt_sel,
  input  logic                       cnt_dir,
  output logic [NTERM-1:0]           err_to_out,
  output logic [NTERM-1:0]           err_to_in,
  output logic [NTERM-1:0]           err_spur,
  output logic [NTERM-1:0]           err_stab,
  output logic                       any_err,
  output logic [CNT_W-1:0]           cnt_rd
);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, TOUT = 2'd2} hs_state_e;

  logic [NTERM-1:0] to_set_out, to_set_in, stab_set, spur_set;
  logic [CNT_W-1:0] cnt_arr [2][NTERM];

  logic [NTERM-1:0] to_out_q, to_out_d, to_in_q, to_in_d;
  logic [NTERM-1:0] spur_q, spur_d, stab_q, stab_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] rd_q, rd_d;

  for (genvar gi = 0; gi < NTERM; gi++) begin : g_ch
    logic [PCKG_SZ-1:0] data_q;
    logic               stall_q, stall_out;

    for (genvar gd = 0; gd < 2; gd++) begin : g_dir
      hs_state_e        state_q, state_d;
      logic [WC_W-1:0]  wcnt_q, wcnt_d, wnext;
      logic [CNT_W-1:0] xcnt_q, xcnt_d;
      logic             pn, pp, stall, to_set;

      assign pn    = (gd == 0) ? pndng[gi] : pndng_i_in[gi];
      assign pp    = (gd == 0) ? pop[gi]   : popin[gi];
      assign stall = pn & ~pp;
      // The first stalled cycle seen from IDLE already counts as wait cycle one.
      assign wnext = (state_q == IDLE) ? WC_W'(1) : wcnt_q + WC_W'(1);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= IDLE;
          wcnt_q  <= '0;
          xcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          wcnt_q  <= wcnt_d;
          xcnt_q  <= xcnt_d;
        end
      end

      always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        to_set  = 1'b0;
        case (state_q)
          IDLE, WAIT: begin
            if (stall) begin
              if (wnext == WC_W'(TIMEOUT)) begin
                state_d = TOUT;
                wcnt_d  = '0;
                to_set  = 1'b1;
              end else begin
                state_d = WAIT;
                wcnt_d  = wnext;
              end
            end else begin
              state_d = IDLE;
              wcnt_d  = '0;
            end
          end
          TOUT: begin
            if (!stall) begin
              state_d = IDLE;
            end else begin
              state_d = TOUT;
            end
            wcnt_d = '0;
          end
          default: begin
            state_d = IDLE;
            wcnt_d  = '0;
          end
        endcase
      end

      always_comb begin
        if (pn && pp && (xcnt_q != {CNT_W{1'b1}})) begin
          xcnt_d = xcnt_q + CNT_W'(1);
        end else begin
          xcnt_d = xcnt_q;
        end
      end

      assign cnt_arr[gd][gi] = xcnt_q;
      if (gd == 0) begin : g_out
        assign to_set_out[gi] = to_set;
      end else begin : g_in
        assign to_set_in[gi] = to_set;
      end
    end

    assign stall_out = pndng[gi] & ~pop[gi];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q  <= '0;
        stall_q <= 1'b0;
      end else begin
        data_q  <= data_out[gi*PCKG_SZ +: PCKG_SZ];
        stall_q <= stall_out;
      end
    end

    assign stab_set[gi] = stall_q & stall_out & (data_out[gi*PCKG_SZ +: PCKG_SZ] != data_q);
  end

  // A new violation wins over clr_err in the same cycle.
  always_comb begin
    spur_set = (pop & ~pndng) | (popin & ~pndng_i_in);
    to_out_d = to_set_out | (to_out_q & ~{NTERM{clr_err}});
    to_in_d  = to_set_in  | (to_in_q  & ~{NTERM{clr_err}});
    spur_d   = spur_set   | (spur_q   & ~{NTERM{clr_err}});
    stab_d   = stab_set   | (stab_q   & ~{NTERM{clr_err}});
    any_d    = |{to_out_q, to_in_q, spur_q, stab_q};
    if (32'(cnt_sel) < 32'(NTERM)) begin
      rd_d = cnt_arr[cnt_dir][cnt_sel];
    end else begin
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_out_q <= '0;
      to_in_q  <= '0;
      spur_q   <= '0;
      stab_q   <= '0;
      any_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      to_out_q <= to_out_d;
      to_in_q  <= to_in_d;
      spur_q   <= spur_d;
      stab_q   <= stab_d;
      any_q    <= any_d;
      rd_q     <= rd_d;
    end
  end

  assign err_to_out = to_out_q;
  assign err_to_in  = to_in_q;
  assign err_spur   = spur_q;
  assign err_stab   = stab_q;
  assign any_err    = any_q;
  assign cnt_rd     = rd_q;
endmodule

// File: doc/mesh_hs_monitor.md
Name: mesh_hs_monitor

Overview:
- Synthesizable, parametrised monitor for the pndng/pop handshake on every terminal of the mesh.
- Covers both directions:
  - mesh-to-terminal: pndng, pop, data_out
  - terminal-to-mesh: pndng_i_in, popin
- Replaces the fixed 16-terminal, bench-only handshake assertions with per-channel timeout, protocol and data-stability checkers, sticky error flags and saturating transfer counters.
- Sits beside mesh_gnrtr, wired to the same interface signals; never drives the DUT.

Parameters:
- NTERM, 16, number of terminals monitored (≥2)
- PCKG_SZ, 40, packet width in bits
- TIMEOUT, 50, maximum cycles pending may stay high without a pop (≥1)
- CNT_W, 16, width of each transfer counter

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pndng  in  NTERM  mesh-to-terminal pending, one bit per terminal
- pop  in  NTERM  terminal pop of mesh output
- data_out  in  NTERM*PCKG_SZ  mesh output data; terminal i at bits [i*PCKG_SZ +: PCKG_SZ]
- pndng_i_in  in  NTERM  terminal-to-mesh pending
- popin  in  NTERM  mesh pop of terminal input
- clr_err  in  1  synchronous clear of all sticky error flags
- cnt_sel  in  $clog2(NTERM)  channel selected for counter readback
- cnt_dir  in  1  0 = out-direction counter, 1 = in-direction counter
- err_to_out  out  NTERM  sticky timeout, mesh-to-terminal
- err_to_in  out  NTERM  sticky timeout, terminal-to-mesh
- err_spur  out  NTERM  sticky: pop or popin asserted while its pending was low
- err_stab  out  NTERM  sticky: data_out changed while pndng=1 and pop=0
- any_err  out  1  OR of all sticky flags (registered)
- cnt_rd  out  CNT_W  selected transfer count

Behaviour:
- Reset (reset=0, async): all err_* = 0, any_err = 0, cnt_rd = 0, all counters = 0, all FSMs in IDLE, wait counters = 0.
- One independent FSM per channel per direction; out direction shown, in direction identical with pndng_i_in/popin.
- States:
  - IDLE → WAIT when pndng=1 and pop=0.
  - IDLE stays IDLE when pndng=1 and pop=1 (same-cycle transfer).
  - WAIT counts cycles of pndng=1 and pop=0 in a $clog2(TIMEOUT+1)-bit wait counter.
  - WAIT → IDLE on pop=1 (transfer) or pndng=0 (withdrawal, no error); wait counter cleared.
  - WAIT → TOUT when the wait counter reaches TIMEOUT; err_to_* set that cycle (visible the next cycle).
  - TOUT holds until pop=1 or pndng=0, then → IDLE; no re-flag while in TOUT.
- Transfer: any rising edge with pndng=1 and pop=1. Counter increments by 1, saturates at 2^CNT_W−1 (no wrap). Back-to-back pops on consecutive cycles count each cycle.
- Spurious pop: pop=1 with pndng=0 sets err_spur[i]. Either direction sets the same bit.
- Stability (out direction only):
  - Register data_out slice each cycle.
  - If pndng=1 and pop=0 on the previous and current cycle and the slice differs, set err_stab[i].
- Sticky flags:
  - Set has priority over clr_err in the same cycle.
  - clr_err=1 clears every flag not being set that cycle.
  - clr_err does not affect counters or FSMs.
- any_err is registered, so it lags flags by one cycle.
- cnt_rd is registered, one-cycle latency from cnt_sel/cnt_dir. cnt_sel ≥ NTERM returns 0.
- Reset mid-operation clears everything immediately; a pending still high after release starts a fresh IDLE→WAIT.

Test Plan:
- Ch3 out: pndng↑, pop after 10 cycles → no flag, out counter ch3 = 1, cnt_rd (sel=3, dir=0) = 1 one cycle after select.
- Ch5 in: pndng_i_in high 50 cycles with popin=0 (TIMEOUT=50) → err_to_in[5]=1 the cycle after 50th wait cycle, any_err one cycle later; popin then → IDLE, count=1, flag stays set.
- Ch0 out: pop=1 with pndng=0 → err_spur[0]=1; clr_err pulse → 0. clr_err in the same cycle as a new violation → flag stays 1.
- Ch7 out: pndng=1, pop=0, data_out slice 0xAA→0xAB → err_stab[7]=1. Change in the same cycle as pop → no flag.
- CNT_W=4, ch1: 20 back-to-back transfers → counter = 15, saturated.
- reset↓ while ch2 in WAIT with flags set → all outputs 0 asynchronously; after release a 50-cycle stall flags again.
